// File: rtl/fir_output_formatter.sv
// Output formatter for the FIR datapath: discards the pipeline-fill warm-up
// samples, decimates, rounds/shifts, saturates to OUT_W and buffers the
// result in a first-word-fall-through FIFO. Sticky flags report clipping and
// FIFO overflow.
module fir_output_formatter #(
    parameter int unsigned IN_W       = 64,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned SHIFT      = 0,
    parameter int unsigned WARMUP_LEN = 102,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_data,
    input  logic [3:0]                 decim,
    input  logic                       clr_flags,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUT_W-1:0]           m_data,
    output logic                       sat_flag,
    output logic                       ovf_flag,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned WCW = (WARMUP_LEN > 0) ? $clog2(WARMUP_LEN + 1) : 1;

    // Saturation bounds expressed at the widened rounding width.
    localparam logic signed [IN_W:0] MaxV = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MinV = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [0:0] {StWarmup, StRun} state_e;

    // With no warm-up the block comes out of reset already running.
    localparam state_e StInit = (WARMUP_LEN == 0) ? StRun : StWarmup;

    state_e             state_q, state_d;
    logic [WCW-1:0]     warm_q, warm_d;
    logic [3:0]         phase_q, phase_d;
    logic [3:0]         dec_q, dec_d;
    logic               fmt_valid_q, fmt_valid_d;
    logic [OUT_W-1:0]   fmt_data_q, fmt_data_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               sat_q, sat_d;
    logic               ovf_q, ovf_d;
    logic [OUT_W-1:0]   mem_q [DEPTH];

    logic               in_run;
    logic               keep;
    logic [3:0]         decim_eff;
    logic [3:0]         period;
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rnd;
    logic [OUT_W-1:0]   sat_val;
    logic               clip;
    logic               pop;
    logic               full;
    logic               push;
    logic               drop;

    assign ext = {in_data[IN_W-1], in_data};

    // Round half up at the widened width so the bias add cannot overflow.
    if (SHIFT > 0) begin : g_round
        localparam logic signed [IN_W:0] Half = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
        assign rnd = (ext + Half) >>> SHIFT;
    end else begin : g_pass
        assign rnd = ext;
    end

    // Clamp the rounded value into the signed output range.
    always_comb begin
        clip    = 1'b0;
        sat_val = rnd[OUT_W-1:0];
        if (rnd > MaxV) begin
            clip    = 1'b1;
            sat_val = MaxV[OUT_W-1:0];
        end else if (rnd < MinV) begin
            clip    = 1'b1;
            sat_val = MinV[OUT_W-1:0];
        end
    end

    // Warm-up FSM: count discarded valid inputs, then run until reset.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        unique case (state_q)
            StWarmup: begin
                if (in_valid) begin
                    if (32'(warm_q) == WARMUP_LEN - 32'd1) begin
                        state_d = StRun;
                    end else begin
                        warm_d = warm_q + WCW'(1);
                    end
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: state_d = StInit;
        endcase
    end

    assign in_run = (state_q == StRun);

    // Decimation: the period in force is latched at each keep (phase 0), so a
    // decim change only applies from the next wrap.
    always_comb begin
        decim_eff = (decim < 4'd2) ? 4'd1 : decim;
        period    = (phase_q == 4'd0) ? decim_eff : dec_q;
        keep      = in_run && in_valid && (phase_q == 4'd0);
        phase_d   = phase_q;
        dec_d     = dec_q;
        if (in_run && in_valid) begin
            phase_d = (phase_q == period - 4'd1) ? 4'd0 : phase_q + 4'd1;
            if (phase_q == 4'd0) begin
                dec_d = decim_eff;
            end
        end
    end

    // Format stage capture, FIFO bookkeeping and sticky flags.
    always_comb begin
        fmt_valid_d = keep;
        fmt_data_d  = keep ? sat_val : fmt_data_q;
        pop         = m_valid && m_ready;
        full        = (level_q == LW'(DEPTH));
        push        = fmt_valid_q && (!full || pop);
        drop        = fmt_valid_q && full && !pop;
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A set event in the same cycle as a clear wins.
        sat_d = (sat_q && !clr_flags) || (keep && clip);
        ovf_d = (ovf_q && !clr_flags) || drop;
    end

    // Control and status state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StInit;
            warm_q      <= '0;
            phase_q     <= '0;
            dec_q       <= 4'd1;
            fmt_valid_q <= 1'b0;
            fmt_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            phase_q     <= phase_d;
            dec_q       <= dec_d;
            fmt_valid_q <= fmt_valid_d;
            fmt_data_q  <= fmt_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage; contents are only visible through level, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fmt_data_q;
        end
    end

    assign m_valid  = (level_q != '0);
    assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign sat_flag = sat_q;
    assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_fir_output_formatter.sv
// Bench for fir_output_formatter: two instances (default parameters, and
// SHIFT=4 with no warm-up) share stimulus and are compared every cycle against
// a queue-based reference model, plus directed scenarios.
module tb_fir_output_formatter;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [3:0]  decim = 4'd1;
    logic        clr_flags = 1'b0;
    logic        m_ready = 1'b0;

    logic        m_valid_a, m_valid_b;
    logic [15:0] m_data_a, m_data_b;
    logic        sat_a, sat_b, ovf_a, ovf_b;
    logic [3:0]  level_a, level_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_output_formatter u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .decim     (decim),
        .clr_flags (clr_flags),
        .m_valid   (m_valid_a),
        .m_ready   (m_ready),
        .m_data    (m_data_a),
        .sat_flag  (sat_a),
        .ovf_flag  (ovf_a),
        .level     (level_a)
    );

    fir_output_formatter #(
        .SHIFT      (4),
        .WARMUP_LEN (0)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .decim     (decim),
        .clr_flags (clr_flags),
        .m_valid   (m_valid_b),
        .m_ready   (m_ready),
        .m_data    (m_data_b),
        .sat_flag  (sat_b),
        .ovf_flag  (ovf_b),
        .level     (level_b)
    );

    // Reference model state, index 0 = instance a, 1 = instance b.
    int     shift_p [2] = '{0, 4};
    int     wl_p    [2] = '{102, 0};
    int     wcnt    [2];
    bit     run     [2];
    int     idx     [2];
    bit     pend_v  [2];
    longint pend_d  [2];
    bit     msat    [2];
    bit     movf    [2];
    longint q0[$], q1[$];
    longint got_a[$], got_b[$];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic longint qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpush(input int d, input longint v);
        if (d == 0) q0.push_back(v);
        else q1.push_back(v);
    endfunction

    function automatic void qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endfunction

    // Round-half-up shift then clamp to the 16-bit signed range.
    function automatic longint fmt(input int d, input logic [63:0] x, output bit clip);
        logic signed [64:0] r;
        int sh;
        sh   = shift_p[d];
        r    = $signed({x[63], x});
        if (sh > 0) r = (r + (65'sd1 <<< (sh - 1))) >>> sh;
        clip = 1'b1;
        if (r > 65'sd32767) return 32767;
        if (r < -65'sd32768) return -32768;
        clip = 1'b0;
        return longint'(r);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            wcnt[d]   = 0;
            run[d]    = (wl_p[d] == 0);
            idx[d]    = 0;
            pend_v[d] = 0;
            pend_d[d] = 0;
            msat[d]   = 0;
            movf[d]   = 0;
        end
        q0.delete();
        q1.delete();
    endfunction

    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            bit full, pop, set_ovf, set_sat, clip;
            int dec;
            full    = (qsize(d) == DEPTH);
            pop     = (qsize(d) > 0) && m_ready;
            set_ovf = 0;
            set_sat = 0;
            if (pop) qpop(d);
            if (pend_v[d]) begin
                if (!full || pop) qpush(d, pend_d[d]);
                else set_ovf = 1;
            end
            pend_v[d] = 0;
            if (in_valid) begin
                if (run[d]) begin
                    dec = (decim < 2) ? 1 : int'(decim);
                    if (idx[d] % dec == 0) begin
                        pend_v[d] = 1;
                        pend_d[d] = fmt(d, in_data, clip);
                        set_sat   = clip;
                    end
                    idx[d]++;
                end else begin
                    wcnt[d]++;
                    if (wcnt[d] == wl_p[d]) run[d] = 1;
                end
            end
            msat[d] = (msat[d] && !clr_flags) || set_sat;
            movf[d] = (movf[d] && !clr_flags) || set_ovf;
        end
    endfunction

    task automatic compare_all();
        check("a.m_valid", longint'(m_valid_a), longint'(qsize(0) > 0));
        check("a.m_data", $signed(m_data_a), (qsize(0) > 0) ? qfront(0) : 0);
        check("a.level", longint'(level_a), qsize(0));
        check("a.sat", longint'(sat_a), longint'(msat[0]));
        check("a.ovf", longint'(ovf_a), longint'(movf[0]));
        check("b.m_valid", longint'(m_valid_b), longint'(qsize(1) > 0));
        check("b.m_data", $signed(m_data_b), (qsize(1) > 0) ? qfront(1) : 0);
        check("b.level", longint'(level_b), qsize(1));
        check("b.sat", longint'(sat_b), longint'(msat[1]));
        check("b.ovf", longint'(ovf_b), longint'(movf[1]));
    endtask

    // One clock: log handshakes, advance the model at the edge, compare after.
    task automatic tick();
        if (m_valid_a && m_ready) got_a.push_back($signed(m_data_a));
        if (m_valid_b && m_ready) got_b.push_back($signed(m_data_b));
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        clr_flags = 1'b0;
        got_a.delete();
        got_b.delete();
    endtask

    task automatic feed(input longint v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic longint rand_data();
        case ($urandom_range(0, 3))
            0: return longint'($urandom_range(0, 80000)) - 64'sd40000;
            1: return longint'($urandom_range(0, 2097152)) - 64'sd1048576;
            2: return {$urandom, $urandom};
            default: begin
                case ($urandom_range(0, 3))
                    0: return 64'sh7fff_ffff_ffff_ffff;
                    1: return 64'sh8000_0000_0000_0000;
                    2: return 0;
                    default: return -1;
                endcase
            end
        endcase
    endfunction

    initial begin
        model_reset();
        #2;
        do_reset();

        // Default instance: warm-up of 102, outputs 102..109.
        decim   = 4'd1;
        m_ready = 1'b1;
        for (int i = 0; i < 110; i++) begin
            feed(i);
            if (i == 102) check("a.first_mv_k", longint'(m_valid_a), 0);
            if (i == 103) check("a.first_mv_k1", longint'(m_valid_a), 1);
        end
        idle(4);
        check("a.count", got_a.size(), 8);
        for (int k = 0; k < got_a.size() && k < 8; k++) check("a.seq", got_a[k], 102 + k);

        // Decimation by 3 with no warm-up.
        do_reset();
        decim = 4'd3;
        m_ready = 1'b1;
        for (int i = 0; i < 9; i++) feed(i * 16);
        idle(4);
        check("b.dec_count", got_b.size(), 3);
        for (int k = 0; k < got_b.size() && k < 3; k++) check("b.dec_seq", got_b[k], 3 * k);

        // Rounding and saturation.
        do_reset();
        decim = 4'd1;
        feed(24);
        feed(-24);
        check("b.sat_pre", longint'(sat_b), 0);
        feed(40000 * 16);
        check("b.sat_post", longint'(sat_b), 1);
        feed(-40000 * 16);
        feed(64'sh7fff_ffff_ffff_ffff);
        idle(4);
        check("b.rnd_count", got_b.size(), 5);
        if (got_b.size() == 5) begin
            check("b.rnd0", got_b[0], 2);
            check("b.rnd1", got_b[1], -1);
            check("b.rnd2", got_b[2], 32767);
            check("b.rnd3", got_b[3], -32768);
            check("b.rnd4", got_b[4], 32767);
        end

        // Overflow: ten inputs into a stalled FIFO.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) feed(i * 16);
        idle(2);
        check("b.full_level", longint'(level_b), 8);
        check("b.ovf_set", longint'(ovf_b), 1);
        m_ready = 1'b1;
        idle(10);
        check("b.ovf_count", got_b.size(), 8);
        for (int k = 0; k < got_b.size() && k < 8; k++) check("b.ovf_seq", got_b[k], k);

        // Full FIFO streaming with simultaneous push and pop.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) feed(i * 16);
        m_ready = 1'b1;
        for (int i = 9; i < 29; i++) begin
            feed(i * 16);
            check("b.stream_level", longint'(level_b), 8);
            check("b.stream_ovf", longint'(ovf_b), 0);
        end
        idle(12);
        check("b.stream_count", got_b.size(), 29);
        for (int k = 0; k < got_b.size() && k < 29; k++) check("b.stream_seq", got_b[k], k);

        // Asynchronous reset with data buffered.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) feed(i * 16);
        idle(1);
        check("b.pre_rst_level", longint'(level_b), 5);
        rst = 1'b1;
        #1;
        check("b.rst_mv", longint'(m_valid_b), 0);
        check("b.rst_level", longint'(level_b), 0);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 106; i++) feed(1000 + i);
        idle(3);
        check("a.rst_first", (got_a.size() > 0) ? got_a[0] : -1, 1102);

        // Randomized episodes against the model.
        for (int ep = 0; ep < 6; ep++) begin
            decim = 4'($urandom_range(0, 15));
            do_reset();
            for (int c = 0; c < 500; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = rand_data();
                m_ready   = (ep % 2 == 0) ? ($urandom_range(0, 1) == 1)
                                          : ($urandom_range(0, 7) != 0);
                clr_flags = ($urandom_range(0, 19) == 0);
                tick();
            end
            in_valid  = 1'b0;
            clr_flags = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
